mux_sel_sequencer: RTL and testbench



---
 rtl/mux_seq_pkg.sv | 10 +
 rtl/mux_sel_sequencer_if.sv | 15 +
 rtl/sync_nff.sv | 17 +
 rtl/mux_sel_sequencer.sv | 74 +++++++
 tb/tb_mux_sel_sequencer.sv | 132 +++++++++++++
 5 files changed

// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types, widths and dwell helper for the mux select sequencer
package mux_seq_pkg;
  localparam int SEL_W   = 2;
  localparam int NCH     = 4;
  localparam int DWELL_W = 4;
  typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;
  function automatic logic [DWELL_W-1:0] dwell_last(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction
endpackage

// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if: control inputs and mux-facing outputs of the select sequencer
interface mux_sel_sequencer_if;
  import mux_seq_pkg::*;
  logic               ena;
  logic [NCH-1:0]     din;
  logic               auto_mode;
  logic [SEL_W-1:0]   man_sel;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel;
  logic [NCH-1:0]     dout;
  logic               sel_stb;
  logic               wrap;
  modport master (output ena, din, auto_mode, man_sel, dwell, input sel, dout, sel_stb, wrap);
  modport slave (input ena, din, auto_mode, man_sel, dwell, output sel, dout, sel_stb, wrap);
endinterface

// File: rtl/sync_nff.sv
// sync_nff: STAGES-deep flop chain synchroniser of width W
module sync_nff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] ff_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  end
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: manual or round-robin channel select for a downstream 4:1 mux
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_sel_sequencer_if.slave  bus
);
  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d, man_s;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]      din_s;
  logic                stb_q, stb_d, wrap_q, wrap_d, auto_s, tick, last;
  sync_nff #(.W(NCH), .STAGES(SYNC_STAGES)) u_din (
    .clk(clk), .rst_n(rst_n), .d_i(bus.din), .q_o(din_s)
  );
  sync_nff #(.W(1), .STAGES(SYNC_STAGES)) u_auto (
    .clk(clk), .rst_n(rst_n), .d_i(bus.auto_mode), .q_o(auto_s)
  );
  sync_nff #(.W(SEL_W), .STAGES(SYNC_STAGES)) u_man (
    .clk(clk), .rst_n(rst_n), .d_i(bus.man_sel), .q_o(man_s)
  );
  assign tick = &psc_q;
  // >= rather than == so a dwell lowered below the count advances on the next tick
  assign last = cnt_q >= dwell_last(bus.dwell);
  always_comb begin
    state_d = !bus.ena ? IDLE : auto_s ? AUTO : MANUAL;
    sel_d   = sel_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    stb_d   = 1'b0;
    wrap_d  = 1'b0;
    if (state_d == MANUAL) begin
      sel_d = man_s;
      stb_d = man_s != sel_q;
    end else if (state_d == AUTO && state_q != AUTO) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (state_d == AUTO) begin
      psc_d = psc_q + PRESCALE_W'(1);
      if (tick) begin
        cnt_d  = last ? '0 : cnt_q + DWELL_W'(1);
        sel_d  = last ? sel_q + SEL_W'(1) : sel_q;
        stb_d  = last;
        wrap_d = last && sel_q == SEL_W'(NCH - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      psc_q   <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      wrap_q  <= wrap_d;
    end
  end
  assign bus.sel     = sel_q;
  assign bus.dout    = din_s;
  assign bus.sel_stb = stb_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: directed checks of sync latency, manual/auto select, ena freeze and reset
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int wrap_cnt = 0;
  mux_sel_sequencer_if bus();
  mux_sel_sequencer #(.SYNC_STAGES(2), .PRESCALE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // outputs sampled on the falling edge; strobe/wrap pulses accumulated as we go
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      stb_cnt += int'(bus.sel_stb);
      wrap_cnt += int'(bus.wrap);
    end
  endtask
  initial begin
    bus.ena = 1'b0;
    bus.din = 4'b0000;
    bus.auto_mode = 1'b0;
    bus.man_sel = 2'd0;
    bus.dwell = 4'd0;
    cyc(3);
    chk("rst_sel", 8'(bus.sel), 8'd0);
    chk("rst_dout", 8'(bus.dout), 8'd0);
    chk("rst_stb", 8'(bus.sel_stb), 8'd0);
    chk("rst_wrap", 8'(bus.wrap), 8'd0);
    chk("rst_state", 8'(dut.state_q), 8'(IDLE));
    rst_n = 1'b1;
    bus.din = 4'b1010;
    cyc(1);
    chk("dout_c1", 8'(bus.dout), 8'h0);
    cyc(1);
    chk("dout_c2", 8'(bus.dout), 8'ha);
    bus.ena = 1'b1;
    bus.man_sel = 2'd2;
    cyc(5);
    chk("man_sel2", 8'(bus.sel), 8'd2);
    chk("man_state", 8'(dut.state_q), 8'(MANUAL));
    bus.man_sel = 2'd1;
    stb_cnt = 0;
    cyc(2);
    chk("man_hold2", 8'(bus.sel), 8'd2);
    cyc(1);
    chk("man_sel1", 8'(bus.sel), 8'd1);
    chk("man_stb", 8'(bus.sel_stb), 8'd1);
    cyc(2);
    chk("man_stb_cnt", 8'(stb_cnt), 8'd1);
    bus.man_sel = 2'd0;
    cyc(4);
    chk("man_sel0", 8'(bus.sel), 8'd0);
    bus.auto_mode = 1'b1;
    bus.dwell = 4'd2;
    stb_cnt = 0;
    wrap_cnt = 0;
    cyc(10);
    chk("auto_hold0", 8'(bus.sel), 8'd0);
    chk("auto_nostb", 8'(stb_cnt), 8'd0);
    cyc(1);
    chk("auto_sel1", 8'(bus.sel), 8'd1);
    chk("auto_stb1", 8'(bus.sel_stb), 8'd1);
    for (int k = 2; k <= 4; k++) begin
      cyc(7);
      chk("auto_hold", 8'(bus.sel), 8'((k - 1) % 4));
      cyc(1);
      chk("auto_adv", 8'(bus.sel), 8'(k % 4));
      chk("auto_stb", 8'(bus.sel_stb), 8'd1);
    end
    chk("auto_wrap", 8'(bus.wrap), 8'd1);
    chk("auto_wrap_cnt", 8'(wrap_cnt), 8'd1);
    bus.dwell = 4'd0;
    stb_cnt = 0;
    wrap_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      chk("dw0_hold", 8'(bus.sel), 8'(k - 1));
      cyc(1);
      chk("dw0_adv", 8'(bus.sel), 8'(k));
    end
    chk("dw0_stb_cnt", 8'(stb_cnt), 8'd3);
    chk("dw0_wrap_cnt", 8'(wrap_cnt), 8'd0);
    bus.ena = 1'b0;
    bus.dwell = 4'd2;
    stb_cnt = 0;
    cyc(10);
    chk("ena_sel", 8'(bus.sel), 8'd3);
    chk("ena_stb_cnt", 8'(stb_cnt), 8'd0);
    chk("ena_state", 8'(dut.state_q), 8'(IDLE));
    bus.ena = 1'b1;
    cyc(8);
    chk("ena_hold", 8'(bus.sel), 8'd3);
    chk("ena_hold_stb", 8'(stb_cnt), 8'd0);
    cyc(1);
    chk("ena_adv", 8'(bus.sel), 8'd0);
    chk("ena_adv_stb", 8'(bus.sel_stb), 8'd1);
    chk("ena_adv_wrap", 8'(bus.wrap), 8'd1);
    cyc(8);
    chk("pre_rst_sel", 8'(bus.sel), 8'd1);
    cyc(5);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_sel", 8'(bus.sel), 8'd0);
    chk("mid_rst_dout", 8'(bus.dout), 8'd0);
    chk("mid_rst_stb", 8'(bus.sel_stb), 8'd0);
    chk("mid_rst_wrap", 8'(bus.wrap), 8'd0);
    chk("mid_rst_state", 8'(dut.state_q), 8'(IDLE));
    rst_n = 1'b1;
    stb_cnt = 0;
    cyc(10);
    chk("post_rst_hold", 8'(bus.sel), 8'd0);
    chk("post_rst_nostb", 8'(stb_cnt), 8'd0);
    cyc(1);
    chk("post_rst_adv", 8'(bus.sel), 8'd1);
    chk("post_rst_stb", 8'(bus.sel_stb), 8'd1);
    chk("post_rst_dout", 8'(bus.dout), 8'ha);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
